// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 widths, schedule FSM states and rotate helper
package sha256_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned BLOCK_WORDS = 16;
   localparam int unsigned NUM_ROUNDS  = 64;

   typedef enum logic {
      LOAD   = 1'b0,
      EXPAND = 1'b1
   } sched_state_e;

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned        n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// rtl/sha256_msg_sched_if.sv - message word in / schedule word out handshake bundle
interface sha256_msg_sched_if;
   import sha256_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_word;
   logic              w_valid;
   logic              w_ready;
   logic [WORD_W-1:0] w_word;
   logic [5:0]        w_idx;
   logic              w_last;

   modport slave (
      input  in_valid, in_word, w_ready,
      output in_ready, w_valid, w_word, w_idx, w_last
   );

   modport master (
      output in_valid, in_word, w_ready,
      input  in_ready, w_valid, w_word, w_idx, w_last
   );

endinterface

// File: rtl/sha256_msg_sched_sig.sv
// rtl/sha256_msg_sched_sig.sv - SHA-256 small sigma functions used by the schedule recurrence
module sha256_sig0
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] x,
   output logic [WORD_W-1:0] y
);
   assign y = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
endmodule

module sha256_sig1
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] x,
   output logic [WORD_W-1:0] y
);
   assign y = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
endmodule

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - loads a 16-word block, then streams W0..W63 from a sliding window
module sha256_msg_sched
   import sha256_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = WORD_W,
   parameter int unsigned NUM_WORDS  = NUM_ROUNDS
) (
   input  logic                clk,
   input  logic                rst_n,
   sha256_msg_sched_if.slave   bus
);

   localparam logic [3:0] LAST_LOAD = 4'(BLOCK_WORDS - 1);
   localparam logic [5:0] LAST_T    = 6'(NUM_WORDS - 1);

   sched_state_e          state_q, state_d;
   logic [3:0]            load_cnt_q, load_cnt_d;
   logic [5:0]            t_q, t_d;
   logic [DATA_WIDTH-1:0] win_q [BLOCK_WORDS];
   logic [DATA_WIDTH-1:0] win_d [BLOCK_WORDS];

   logic [DATA_WIDTH-1:0] sig0_y;
   logic [DATA_WIDTH-1:0] sig1_y;
   logic [DATA_WIDTH-1:0] next_word;

   sha256_sig0 u_sig0 (.x(win_q[1]),  .y(sig0_y));
   sha256_sig1 u_sig1 (.x(win_q[14]), .y(sig1_y));

   // Window index k holds W(t+k); the new tail is W(t+16) from pre-shift taps.
   assign next_word = sig1_y + win_q[9] + sig0_y + win_q[0];

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      t_d        = t_q;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
         win_d[i] = win_q[i];
      end

      case (state_q)
         LOAD: begin
            if (bus.in_valid) begin
               win_d[load_cnt_q] = bus.in_word;
               load_cnt_d        = load_cnt_q + 4'd1;
               if (load_cnt_q == LAST_LOAD) begin
                  state_d = EXPAND;
                  t_d     = '0;
               end
            end
         end
         EXPAND: begin
            if (bus.w_ready) begin
               for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                  win_d[i] = win_q[i+1];
               end
               win_d[BLOCK_WORDS-1] = next_word;
               if (t_q == LAST_T) begin
                  state_d    = LOAD;
                  load_cnt_d = '0;
                  t_d        = '0;
               end else begin
                  t_d = t_q + 6'd1;
               end
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= LOAD;
         load_cnt_q <= '0;
         t_q        <= '0;
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         t_q        <= t_d;
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

   // All outputs decode straight from flops, so nothing combinational reaches them from inputs.
   assign bus.in_ready = (state_q == LOAD);
   assign bus.w_valid  = (state_q == EXPAND);
   assign bus.w_word   = win_q[0];
   assign bus.w_idx    = t_q;
   assign bus.w_last   = (state_q == EXPAND) && (t_q == LAST_T);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - scoreboard bench for the SHA-256 message schedule expander
module tb_sha256_msg_sched;

   typedef logic [31:0] blk_t [16];

   typedef struct {
      logic [31:0] word;
      logic [5:0]  idx;
      logic        last;
   } exp_t;

   logic clk;
   logic rst_n;
   sha256_msg_sched_if bus ();

   sha256_msg_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors;
   int          checks;
   exp_t        sb[$];
   logic [31:0] dut_log [64];
   int          words_seen;
   int          last_seen;
   bit          rand_rdy;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
   endfunction

   task automatic push_expected(input blk_t m);
      logic [31:0] w [64];
      exp_t e;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = m[t];
         else        w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
         e.word = w[t];
         e.idx  = 6'(t);
         e.last = (t == 63);
         sb.push_back(e);
      end
   endtask

   task automatic load_block(input blk_t m, input bit gaps);
      bit rdy;
      int n;
      for (int i = 0; i < 16; i++) begin
         n   = 0;
         rdy = 1'b0;
         while (!rdy && n < 400) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
               bus.in_valid = 1'b0;
               bus.in_word  = $urandom;
            end else begin
               bus.in_valid = 1'b1;
               bus.in_word  = m[i];
               rdy          = bus.in_ready;
            end
            @(posedge clk);
            #1;
            n++;
         end
         if (!rdy) begin
            check("load_timeout", 64'(i), 64'd16);
            bus.in_valid = 1'b0;
            return;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_word  = $urandom;
      push_expected(m);
      @(negedge clk);
      check("lat_w_valid", bus.w_valid, 1);
      check("lat_w_idx", bus.w_idx, 0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      check("drain_left", sb.size(), 0);
      #1;
      check("drain_in_ready", bus.in_ready, 1);
      check("drain_w_valid", bus.w_valid, 0);
   endtask

   // Downstream ready: always high, or a fair coin per cycle when rand_rdy is set.
   initial begin
      bus.w_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.w_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      bit          prev_stall;
      logic [31:0] prev_word;
      logic [5:0]  prev_idx;
      exp_t        e;
      prev_stall = 1'b0;
      prev_word  = '0;
      prev_idx   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall) begin
            check("stall_valid", bus.w_valid, 1);
            check("stall_word", bus.w_word, prev_word);
            check("stall_idx", bus.w_idx, prev_idx);
         end
         if (bus.w_valid) check("in_ready_in_expand", bus.in_ready, 0);
         if (bus.w_valid && bus.w_ready) begin
            if (sb.size() == 0) begin
               check("sb_underflow", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               check("w_word", bus.w_word, e.word);
               check("w_idx", bus.w_idx, e.idx);
               check("w_last", bus.w_last, e.last);
               dut_log[bus.w_idx] = bus.w_word;
               words_seen++;
               if (bus.w_last) last_seen++;
            end
         end
         prev_stall = bus.w_valid && !bus.w_ready;
         prev_word  = bus.w_word;
         prev_idx   = bus.w_idx;
      end
   end

   initial begin
      blk_t abc, zero, rnd_a, rnd_b;
      int   n;
      errors   = 0;
      checks   = 0;
      rand_rdy = 1'b0;
      words_seen = 0;
      last_seen  = 0;
      for (int i = 0; i < 16; i++) begin
         abc[i]   = 32'h0;
         zero[i]  = 32'h0;
         rnd_a[i] = $urandom;
         rnd_b[i] = $urandom;
      end
      abc[0]  = 32'h61626380;
      abc[15] = 32'h00000018;

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_word  = $urandom;
      repeat (2) @(posedge clk);
      #1;
      check("rst_w_valid", bus.w_valid, 0);
      check("rst_w_idx", bus.w_idx, 0);
      check("rst_w_last", bus.w_last, 0);
      check("rst_w_word", bus.w_word, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1);

      // "abc" block, full-rate drain
      load_block(abc, 1'b0);
      wait_drain();
      check("abc_w16", dut_log[16], 32'h61626380);
      check("abc_w17", dut_log[17], 32'h000F0000);
      check("abc_count", words_seen, 64);
      check("abc_lasts", last_seen, 1);

      // all-zero block
      load_block(zero, 1'b0);
      wait_drain();
      check("zero_w63", dut_log[63], 0);

      // "abc" with random backpressure
      rand_rdy = 1'b1;
      load_block(abc, 1'b0);
      wait_drain();
      rand_rdy = 1'b0;
      #1;

      // two blocks back to back, in_valid held high through the first expansion
      words_seen = 0;
      load_block(rnd_a, 1'b0);
      load_block(rnd_b, 1'b0);
      wait_drain();
      check("b2b_count", words_seen, 128);

      // reset in the middle of expansion
      load_block(abc, 1'b0);
      n = 0;
      while (!(bus.w_valid && bus.w_idx == 6'd20) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("reach_idx20", bus.w_idx, 20);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_w_valid", bus.w_valid, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_w_idx", bus.w_idx, 0);
      load_block(rnd_a, 1'b0);
      wait_drain();

      // gapped load must match the contiguous one
      load_block(rnd_b, 1'b1);
      wait_drain();
      rand_rdy = 1'b1;
      load_block(rnd_a, 1'b1);
      wait_drain();
      rand_rdy = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
